// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I multi-cycle control sequencer:
// opcodes, FSM state encoding, mux-select encodings and trap causes.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } ctrl_state_t;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'b00,
        PC_IMM   = 2'b01,
        PC_ALU   = 2'b10
    } pc_sel_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_IMM  = 2'b11
    } wb_sel_t;

    typedef enum logic [1:0] {
        CAUSE_NONE         = 2'd0,
        CAUSE_ILLEGAL      = 2'd1,
        CAUSE_IMEM_TIMEOUT = 2'd2,
        CAUSE_DMEM_TIMEOUT = 2'd3
    } trap_cause_t;

    // Full 7-bit match, so a non-11 low pair and SYSTEM both fall out as illegal.
    function automatic logic opcode_legal(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic uses_imm_op2(input logic [6:0] opc);
        case (opc)
            OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_JALR, OPC_AUIPC: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic writes_rd(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_LOAD, OPC_OP_IMM, OPC_OP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_wait_timer.sv
// Handshake wait counter shared by the FETCH and MEM waits; flags expiry
// once the count reaches LIMIT while still enabled.
module rv32i_wait_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LIMIT_W = LIMIT[15:0];

    logic [15:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 16'd1;
        end
    end

    assign expired = enable && (count == LIMIT_W);

endmodule

// File: rtl/rv32i_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Define RV32I_CTRL_PERF_EN to add cycle_cnt/instret_cnt performance counters.
module rv32i_ctrl_fsm
    import rv32i_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        ir_we,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        br_taken,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        op2_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        trap,
`ifdef RV32I_CTRL_PERF_EN
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt,
`endif
    output logic [1:0]  trap_cause
);

    ctrl_state_t state, state_nxt;
    trap_cause_t cause_q, cause_nxt;
    pc_sel_t     pc_sel_v;
    wb_sel_t     wb_sel_v;
    logic        br_taken_q;
    logic        wait_st;
    logic        timer_expired;
    logic [6:0]  opc;
    logic        rd_nonzero;
    logic        instr_unused;

    assign opc          = instr[6:0];
    assign rd_nonzero   = (instr[11:7] != 5'd0);
    assign instr_unused = ^instr[31:12];
    assign wait_st      = (state == ST_FETCH) || (state == ST_MEM);

    rv32i_wait_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!wait_st),
        .enable (wait_st),
        .expired(timer_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_FETCH;
            cause_q    <= CAUSE_NONE;
            br_taken_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cause_q <= cause_nxt;
            if (state == ST_EXEC && opc == OPC_BRANCH) begin
                br_taken_q <= br_taken;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        cause_nxt  = cause_q;
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        pc_we      = 1'b0;
        pc_sel_v   = PC_PLUS4;
        op2_sel    = 1'b0;
        rf_we      = 1'b0;
        wb_sel_v   = WB_ALU;
        trap       = 1'b0;

        case (state)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we     = 1'b1;
                    state_nxt = ST_DECODE;
                end else if (timer_expired) begin
                    state_nxt = ST_TRAP;
                    cause_nxt = CAUSE_IMEM_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (opcode_legal(opc)) begin
                    state_nxt = ST_EXEC;
                end else begin
                    state_nxt = ST_TRAP;
                    cause_nxt = CAUSE_ILLEGAL;
                end
            end
            ST_EXEC: begin
                op2_sel   = uses_imm_op2(opc);
                state_nxt = (opc == OPC_LOAD || opc == OPC_STORE) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opc == OPC_STORE);
                if (dmem_ack) begin
                    state_nxt = ST_WB;
                end else if (timer_expired) begin
                    state_nxt = ST_TRAP;
                    cause_nxt = CAUSE_DMEM_TIMEOUT;
                end
            end
            ST_WB: begin
                pc_we = 1'b1;
                if (opc == OPC_JAL || (opc == OPC_BRANCH && br_taken_q)) begin
                    pc_sel_v = PC_IMM;
                end else if (opc == OPC_JALR) begin
                    pc_sel_v = PC_ALU;
                end
                rf_we = writes_rd(opc) && rd_nonzero;
                case (opc)
                    OPC_LUI:           wb_sel_v = WB_IMM;
                    OPC_JAL, OPC_JALR: wb_sel_v = WB_PC4;
                    OPC_LOAD:          wb_sel_v = WB_LOAD;
                    default:           wb_sel_v = WB_ALU;
                endcase
                state_nxt = ST_FETCH;
            end
            ST_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_nxt = ST_FETCH;
            end
        endcase

        // Outputs are forced quiet while reset is held, even before the state register updates.
        if (reset) begin
            imem_req = 1'b0;
            ir_we    = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            pc_we    = 1'b0;
            op2_sel  = 1'b0;
            rf_we    = 1'b0;
            trap     = 1'b0;
        end
    end

    assign pc_sel     = pc_sel_v;
    assign wb_sel     = wb_sel_v;
    assign trap_cause = reset ? 2'd0 : cause_q;

`ifdef RV32I_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state != ST_TRAP) begin
                cycle_cnt <= cycle_cnt + 64'd1;
            end
            if (state == ST_WB) begin
                instret_cnt <= instret_cnt + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rv32i_ctrl_fsm.sv
// Cycle-level scoreboard bench for rv32i_ctrl_fsm: the driver pushes each
// cycle's expected outputs, a negedge monitor pops and compares them.
module tb_rv32i_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        imem_req, imem_ack, ir_we;
    logic        dmem_req, dmem_we, dmem_ack;
    logic        br_taken, pc_we, op2_sel, rf_we, trap;
    logic [1:0]  pc_sel, wb_sel, trap_cause;
`ifdef RV32I_CTRL_PERF_EN
    logic [63:0] cycle_cnt, instret_cnt;
`endif

    always #5 clk = ~clk;

    rv32i_ctrl_fsm #(
        .TIMEOUT_CYCLES(3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .ir_we      (ir_we),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .br_taken   (br_taken),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .op2_sel    (op2_sel),
        .rf_we      (rf_we),
        .wb_sel     (wb_sel),
        .trap       (trap),
`ifdef RV32I_CTRL_PERF_EN
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt),
`endif
        .trap_cause (trap_cause)
    );

    // Bit layout: imem_req ir_we dmem_req dmem_we pc_we pc_sel[2] op2_sel rf_we wb_sel[2] trap cause[2]
    logic [13:0] act;
    assign act = {imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel,
                  op2_sel, rf_we, wb_sel, trap, trap_cause};

    localparam logic [13:0] M_BASE = 14'b11_1_0_1_00_0_1_00_1_11;
    localparam logic [13:0] M_DWE  = 14'b00_0_1_0_00_0_0_00_0_00;
    localparam logic [13:0] M_PCS  = 14'b00_0_0_0_11_0_0_00_0_00;
    localparam logic [13:0] M_OP2  = 14'b00_0_0_0_00_1_0_00_0_00;
    localparam logic [13:0] M_WBS  = 14'b00_0_0_0_00_0_0_11_0_00;

    typedef struct {
        logic [13:0] val;
        logic [13:0] mask;
        string       tag;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        int unsigned iw;
        int unsigned dw;
        bit          br;
        bit          mem;
        bit          st;
        bit          op2;
        logic [1:0]  pcs;
        bit          rfwe;
        logic [1:0]  wbs;
    } vec_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic logic [13:0] ov(bit ireq, bit irwe, bit dreq, bit dwe, bit pcwe,
                                       logic [1:0] pcs, bit op2, bit rfwe, logic [1:0] wbs,
                                       bit trp, logic [1:0] cause);
        return {ireq, irwe, dreq, dwe, pcwe, pcs, op2, rfwe, wbs, trp, cause};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_cmp++;
            if ((act & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL %s: outputs %b, required %b (mask %b)", e.tag, act, e.val, e.mask);
            end
        end
    end

    task automatic step(input bit rst, input logic [31:0] ins, input bit iack, input bit dack,
                        input bit br, input logic [13:0] ev, input logic [13:0] em, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        reset    = rst;
        instr    = ins;
        imem_ack = iack;
        dmem_ack = dack;
        br_taken = br;
        e.val  = ev;
        e.mask = em;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        step(1, 32'h0, 1, 1, 0, '0, M_BASE, "reset");
    endtask

    // br_taken carries the wanted value only in EXEC; the inverse elsewhere exercises the latch.
    task automatic run_vec(input vec_t v);
        for (int unsigned i = 0; i <= v.iw; i++)
            step(0, v.instr, i == v.iw, 0, ~v.br,
                 ov(1, i == v.iw, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'd0), M_BASE, {v.name, ":fetch"});
        step(0, v.instr, 1, 1, ~v.br, '0, M_BASE, {v.name, ":decode"});
        step(0, v.instr, 0, 0, v.br,
             ov(0, 0, 0, 0, 0, 2'b00, v.op2, 0, 2'b00, 0, 2'd0), M_BASE | M_OP2, {v.name, ":exec"});
        if (v.mem)
            for (int unsigned i = 0; i <= v.dw; i++)
                step(0, v.instr, 0, i == v.dw, ~v.br,
                     ov(0, 0, 1, v.st, 0, 2'b00, 0, 0, 2'b00, 0, 2'd0), M_BASE | M_DWE, {v.name, ":mem"});
        step(0, v.instr, 1, 1, ~v.br,
             ov(0, 0, 0, 0, 1, v.pcs, 0, v.rfwe, v.wbs, 0, 2'd0), M_BASE | M_PCS | M_WBS, {v.name, ":wb"});
    endtask

    vec_t vecs[13];

    initial begin
        reset = 1'b1; instr = '0; imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0;

        //            name           instr         iw dw br mem st op2 pcs    rf wbs
        vecs[0]  = '{"addi_x1",    32'h00500093, 0, 0, 0, 0, 0, 1, 2'b00, 1, 2'b00};
        vecs[1]  = '{"lw_late3",   32'h0000A103, 0, 3, 0, 1, 0, 1, 2'b00, 1, 2'b01};
        vecs[2]  = '{"beq_taken",  32'h00000463, 0, 0, 1, 0, 0, 0, 2'b01, 0, 2'b00};
        vecs[3]  = '{"beq_nt",     32'h00000463, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00};
        vecs[4]  = '{"addi_x0",    32'h00500013, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00};
        vecs[5]  = '{"sw",         32'h0020A223, 0, 1, 0, 1, 1, 1, 2'b00, 0, 2'b00};
        vecs[6]  = '{"lui",        32'h123452B7, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b11};
        vecs[7]  = '{"auipc",      32'h00001317, 0, 0, 0, 0, 0, 1, 2'b00, 1, 2'b00};
        vecs[8]  = '{"jal",        32'h010000EF, 0, 0, 0, 0, 0, 0, 2'b01, 1, 2'b10};
        vecs[9]  = '{"jalr_x0",    32'h00008067, 0, 0, 0, 0, 0, 1, 2'b10, 0, 2'b10};
        vecs[10] = '{"add_iw2",    32'h002081B3, 2, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00};
        vecs[11] = '{"fence",      32'h0FF0000F, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00};
        vecs[12] = '{"addi_iw3",   32'h00500093, 3, 0, 0, 0, 0, 1, 2'b00, 1, 2'b00};

        do_reset();
        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // ECALL traps as illegal and stays quiet, ignoring acks, until reset.
        step(0, 32'h00000073, 1, 0, 0, ov(1, 1, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'd0), M_BASE, "ecall:fetch");
        step(0, 32'h00000073, 0, 0, 0, '0, M_BASE, "ecall:decode");
        for (int i = 0; i < 22; i++)
            step(0, 32'h00000073, i[0], ~i[0], 0,
                 ov(0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1, 2'd1), M_BASE, "ecall:trap");
        do_reset();

        // Fetch never acked: four request cycles, then cause 2.
        for (int i = 0; i < 4; i++)
            step(0, 32'h00500093, 0, 0, 0, ov(1, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'd0), M_BASE, "imem_to:req");
        for (int i = 0; i < 3; i++)
            step(0, 32'h00500093, 0, 0, 0, ov(0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1, 2'd2), M_BASE, "imem_to:trap");
        do_reset();

        // Load never acked: four request cycles, then cause 3.
        step(0, 32'h0000A103, 1, 0, 0, ov(1, 1, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'd0), M_BASE, "dmem_to:fetch");
        step(0, 32'h0000A103, 0, 0, 0, '0, M_BASE, "dmem_to:decode");
        step(0, 32'h0000A103, 0, 0, 0, ov(0, 0, 0, 0, 0, 2'b00, 1, 0, 2'b00, 0, 2'd0), M_BASE | M_OP2, "dmem_to:exec");
        for (int i = 0; i < 4; i++)
            step(0, 32'h0000A103, 0, 0, 0, ov(0, 0, 1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'd0), M_BASE | M_DWE, "dmem_to:req");
        for (int i = 0; i < 3; i++)
            step(0, 32'h0000A103, 0, 0, 0, ov(0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1, 2'd3), M_BASE, "dmem_to:trap");
        do_reset();

        // Reset during an in-flight store drops the request; FETCH resumes after release.
        step(0, 32'h0020A223, 1, 0, 0, ov(1, 1, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'd0), M_BASE, "rst_mem:fetch");
        step(0, 32'h0020A223, 0, 0, 0, '0, M_BASE, "rst_mem:decode");
        step(0, 32'h0020A223, 0, 0, 0, ov(0, 0, 0, 0, 0, 2'b00, 1, 0, 2'b00, 0, 2'd0), M_BASE | M_OP2, "rst_mem:exec");
        step(0, 32'h0020A223, 0, 0, 0, ov(0, 0, 1, 1, 0, 2'b00, 0, 0, 2'b00, 0, 2'd0), M_BASE | M_DWE, "rst_mem:req");
        step(1, 32'h0020A223, 0, 1, 0, '0, M_BASE, "rst_mem:reset");
        step(0, 32'h0020A223, 0, 1, 0, ov(1, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'd0), M_BASE, "rst_mem:refetch");
        run_vec(vecs[0]);

`ifdef RV32I_CTRL_PERF_EN
        do_reset();
        for (int i = 0; i < 3; i++) run_vec(vecs[0]);
        step(0, 32'h00500093, 0, 0, 0, ov(1, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'd0), M_BASE, "perf:fetch");
        n_cmp++;
        if (instret_cnt !== 64'd3) begin
            n_fail++;
            $display("FAIL instret_cnt: got %0d, required 3", instret_cnt);
        end
        n_cmp++;
        if (cycle_cnt !== 64'd12) begin
            n_fail++;
            $display("FAIL cycle_cnt: got %0d, required 12", cycle_cnt);
        end
`endif

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
